// File: rtl/snake_body.sv
// Snake segment ring buffer and playfield occupancy map. A move tick goes
// RUN -> CHECK -> COMMIT. The head, tail and shift_snake outputs update at the commit edge.
module snake_body #(
  parameter int H        = 32,
  parameter int V        = 32,
  parameter int MAXLEN   = 64,
  parameter int INIT_LEN = 3,
  localparam int XW = $clog2(H),
  localparam int YW = $clog2(V),
  localparam int LW = $clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [1:0]    dir,
  input  logic          grow,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          query_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [XW-1:0] tail_x,
  output logic [YW-1:0] tail_y,
  output logic          shift_snake,
  output logic [LW-1:0] length,
  output logic          dead
);
  localparam int PW = $clog2(MAXLEN);
  localparam int MW = $clog2(H * V);
  localparam int NC = H * V;
  localparam logic [XW-1:0] HX0 = XW'(H / 2);
  localparam logic [YW-1:0] HY0 = YW'(V / 2);
  localparam logic [XW-1:0] TX0 = XW'(H / 2 - INIT_LEN + 1);

  typedef enum logic [1:0] {RUN, CHECK, COMMIT, DEAD} state_t;

  function automatic logic [MW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return MW'(y) * MW'(H) + MW'(x);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAXLEN - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [NC-1:0] init_map();
    logic [NC-1:0] m;
    m = '0;
    for (int i = 0; i < INIT_LEN; i++) m[cell_idx(TX0 + XW'(i), HY0)] = 1'b1;
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    dir_q, dir_d, eff_dir;
  logic [XW-1:0] nxt_x_q, nxt_x_d, head_x_q, head_x_d, tail_x_q, tail_x_d;
  logic [YW-1:0] nxt_y_q, nxt_y_d, head_y_q, head_y_d, tail_y_q, tail_y_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
  logic [LW-1:0] length_q, length_d;
  logic          grow_pending_q, grow_pending_d, growing_q, growing_d;
  logic          shift_q, shift_d, dead_q, dead_d, query_hit_q, query_hit_d;
  logic [NC-1:0] map_q, map_d;
  logic          wall, self_hit, ring_we;
  logic [XW-1:0] ring_x_q [MAXLEN];
  logic [YW-1:0] ring_y_q [MAXLEN];

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    eff_dir        = dir_q;
    nxt_x_d        = nxt_x_q;
    nxt_y_d        = nxt_y_q;
    head_x_d       = head_x_q;
    head_y_d       = head_y_q;
    tail_x_d       = tail_x_q;
    tail_y_d       = tail_y_q;
    head_ptr_d     = head_ptr_q;
    tail_ptr_d     = tail_ptr_q;
    length_d       = length_q;
    grow_pending_d = grow_pending_q | grow;
    growing_d      = growing_q;
    shift_d        = 1'b0;
    dead_d         = dead_q;
    map_d          = map_q;
    ring_we        = 1'b0;
    wall           = 1'b0;
    self_hit       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (tick) begin
          // A reversal would fold the head back into the neck, so it is ignored.
          eff_dir = (dir == (dir_q ^ 2'd2)) ? dir_q : dir;
          dir_d   = eff_dir;
          nxt_x_d = head_x_q;
          nxt_y_d = head_y_q;
          case (eff_dir)
            2'd0:    nxt_y_d = head_y_q - YW'(1);
            2'd1:    nxt_x_d = head_x_q + XW'(1);
            2'd2:    nxt_y_d = head_y_q + YW'(1);
            default: nxt_x_d = head_x_q - XW'(1);
          endcase
          state_d = CHECK;
        end
      end
      CHECK: begin
        growing_d      = (grow_pending_q | grow) && (length_q < LW'(MAXLEN));
        grow_pending_d = 1'b0;
        case (dir_q)
          2'd0:    wall = (head_y_q == '0);
          2'd1:    wall = (head_x_q == XW'(H - 1));
          2'd2:    wall = (head_y_q == YW'(V - 1));
          default: wall = (head_x_q == '0);
        endcase
        // Stepping into the tail cell is legal when the tail moves away this turn.
        self_hit = map_q[cell_idx(nxt_x_q, nxt_y_q)] &&
                   !((nxt_x_q == tail_x_q) && (nxt_y_q == tail_y_q) && !growing_d);
        if (wall || self_hit) begin
          state_d = DEAD;
          dead_d  = 1'b1;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        head_ptr_d = ptr_inc(head_ptr_q);
        ring_we    = 1'b1;
        head_x_d   = nxt_x_q;
        head_y_d   = nxt_y_q;
        if (growing_q) begin
          length_d = length_q + LW'(1);
        end else begin
          map_d[cell_idx(tail_x_q, tail_y_q)] = 1'b0;
          tail_ptr_d = ptr_inc(tail_ptr_q);
          tail_x_d   = ring_x_q[tail_ptr_d];
          tail_y_d   = ring_y_q[tail_ptr_d];
        end
        map_d[cell_idx(nxt_x_q, nxt_y_q)] = 1'b1;
        shift_d = 1'b1;
        state_d = RUN;
      end
      default: ;
    endcase
    query_hit_d = ({1'b0, query_x} < (XW + 1)'(H)) && ({1'b0, query_y} < (YW + 1)'(V)) &&
                  map_q[cell_idx(query_x, query_y)];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      dir_q          <= 2'd1;
      nxt_x_q        <= HX0;
      nxt_y_q        <= HY0;
      head_x_q       <= HX0;
      head_y_q       <= HY0;
      tail_x_q       <= TX0;
      tail_y_q       <= HY0;
      head_ptr_q     <= PW'(INIT_LEN - 1);
      tail_ptr_q     <= '0;
      length_q       <= LW'(INIT_LEN);
      grow_pending_q <= 1'b0;
      growing_q      <= 1'b0;
      shift_q        <= 1'b0;
      dead_q         <= 1'b0;
      query_hit_q    <= 1'b0;
      map_q          <= init_map();
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      nxt_x_q        <= nxt_x_d;
      nxt_y_q        <= nxt_y_d;
      head_x_q       <= head_x_d;
      head_y_q       <= head_y_d;
      tail_x_q       <= tail_x_d;
      tail_y_q       <= tail_y_d;
      head_ptr_q     <= head_ptr_d;
      tail_ptr_q     <= tail_ptr_d;
      length_q       <= length_d;
      grow_pending_q <= grow_pending_d;
      growing_q      <= growing_d;
      shift_q        <= shift_d;
      dead_q         <= dead_d;
      query_hit_q    <= query_hit_d;
      map_q          <= map_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < INIT_LEN; i++) begin
        ring_x_q[i] <= TX0 + XW'(i);
        ring_y_q[i] <= HY0;
      end
    end else if (ring_we) begin
      ring_x_q[head_ptr_d] <= nxt_x_q;
      ring_y_q[head_ptr_d] <= nxt_y_q;
    end
  end

  assign query_hit   = query_hit_q;
  assign head_x      = head_x_q;
  assign head_y      = head_y_q;
  assign tail_x      = tail_x_q;
  assign tail_y      = tail_y_q;
  assign shift_snake = shift_q;
  assign length      = length_q;
  assign dead        = dead_q;
endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: the stimulus side pushes expected move results
// from a segment-queue model, and a negedge monitor pops them on each shift_snake pulse.
module tb_snake_body;
  localparam int H = 32, V = 32, MAXLEN = 64, INIT_LEN = 3;

  logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, grow = 1'b0;
  logic [1:0] dir = 2'd1;
  logic [4:0] query_x = '0, query_y = '0;
  logic       query_hit, shift_snake, dead;
  logic [4:0] head_x, head_y, tail_x, tail_y;
  logic [6:0] length;

  snake_body #(.H(H), .V(V), .MAXLEN(MAXLEN), .INIT_LEN(INIT_LEN)) dut (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .grow(grow),
    .query_x(query_x), .query_y(query_y), .query_hit(query_hit),
    .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .shift_snake(shift_snake), .length(length), .dead(dead)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct {int hx; int hy; int tx; int ty; int len; int cyc;} exp_t;
  typedef struct {int x; int y;} cell_t;
  exp_t  sb[$];
  cell_t body[$];
  int    m_dir;
  bit    m_dead;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (shift_snake) begin
      if (sb.size() == 0) begin
        check("unexpected shift_snake", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("shift cycle", cyc, e.cyc);
        check("shift head_x", head_x, e.hx);
        check("shift head_y", head_y, e.hy);
        check("shift tail_x", tail_x, e.tx);
        check("shift tail_y", tail_y, e.ty);
        check("shift length", length, e.len);
      end
    end
  end

  function automatic void model_reset();
    cell_t c;
    body.delete();
    for (int i = 0; i < INIT_LEN; i++) begin
      c.x = H / 2 - INIT_LEN + 1 + i;
      c.y = V / 2;
      body.push_back(c);
    end
    m_dir  = 1;
    m_dead = 1'b0;
  endfunction

  function automatic void model_step(input int d, input bit g, input int ecyc);
    cell_t h, n;
    int    eff;
    bit    growing, hit;
    exp_t  e;
    if (m_dead) return;
    eff   = (d == (m_dir ^ 2)) ? m_dir : d;
    m_dir = eff;
    h     = body[body.size() - 1];
    n     = h;
    hit   = 1'b0;
    case (eff)
      0: begin hit = (h.y == 0);     n.y = h.y - 1; end
      1: begin hit = (h.x == H - 1); n.x = h.x + 1; end
      2: begin hit = (h.y == V - 1); n.y = h.y + 1; end
      default: begin hit = (h.x == 0); n.x = h.x - 1; end
    endcase
    growing = g && (body.size() < MAXLEN);
    for (int i = 0; i < body.size(); i++)
      if (body[i].x == n.x && body[i].y == n.y && !(i == 0 && !growing)) hit = 1'b1;
    if (hit) begin
      m_dead = 1'b1;
      return;
    end
    body.push_back(n);
    if (!growing) void'(body.pop_front());
    e.hx = n.x; e.hy = n.y;
    e.tx = body[0].x; e.ty = body[0].y;
    e.len = body.size(); e.cyc = ecyc;
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0; grow = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Optional one-cycle grow pulse, then a one-cycle tick; the pulse is due 3 edges later.
  task automatic move(input int d, input bit g);
    if (g) begin
      @(negedge clk); grow = 1'b1;
      @(negedge clk); grow = 1'b0;
    end else begin
      @(negedge clk);
    end
    dir  = 2'(d);
    tick = 1'b1;
    model_step(d, g, cyc + 3);
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    check("pending expectations", sb.size(), 0);
    sb.delete();
    check("dead", dead, int'(m_dead));
    check("head_x", head_x, body[body.size() - 1].x);
    check("head_y", head_y, body[body.size() - 1].y);
    check("length", length, body.size());
  endtask

  task automatic check_query(input int x, input int y, input int e);
    @(negedge clk); query_x = 5'(x); query_y = 5'(y);
    @(negedge clk); check($sformatf("query(%0d,%0d)", x, y), query_hit, e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("reset head_x", head_x, 16);
    check("reset head_y", head_y, 16);
    check("reset tail_x", tail_x, 14);
    check("reset tail_y", tail_y, 16);
    check("reset length", length, 3);
    check("reset dead", dead, 0);
    check("reset shift", shift_snake, 0);
    check_query(15, 16, 1);
    check_query(17, 16, 0);
    check_query(14, 16, 1);

    move(1, 1'b0);
    check("move tail_x", tail_x, 15);
    check_query(14, 16, 0);
    check_query(17, 16, 1);

    do_reset();
    move(1, 1'b1);
    check("grow tail_x", tail_x, 14);
    check("grow length", length, 4);
    move(1, 1'b0);
    check("after grow tail_x", tail_x, 15);
    check("after grow length", length, 4);

    // Reverse is ignored, then run up into the top wall.
    do_reset();
    move(3, 1'b0);
    check("reverse head_x", head_x, 17);
    for (int i = 0; i < 16; i++) move(0, 1'b0);
    check("top row head_y", head_y, 0);
    move(0, 1'b0);
    check("wall dead", dead, 1);
    move(1, 1'b0);
    check("frozen head_x", head_x, 17);
    check("frozen head_y", head_y, 0);
    do_reset();
    check("recover dead", dead, 0);
    check("recover head_y", head_y, 16);

    // Length 5 loop bites the body.
    do_reset();
    move(1, 1'b1); move(1, 1'b1);
    move(1, 1'b0); move(2, 1'b0); move(3, 1'b0); move(0, 1'b0);
    check("self hit dead", dead, 1);

    // Length 4 loop enters the vacating tail cell.
    do_reset();
    move(1, 1'b1);
    move(1, 1'b0); move(2, 1'b0); move(3, 1'b0); move(0, 1'b0);
    check("tail chase alive", dead, 0);
    check("tail chase head_x", head_x, 17);
    check("tail chase head_y", head_y, 16);
    check_query(17, 16, 1);

    // Serpentine to full length, then a grow at MAXLEN.
    do_reset();
    for (int i = 0; i < 15; i++) move(1, 1'b1);
    move(2, 1'b1);
    for (int i = 0; i < 31; i++) move(3, 1'b1);
    move(2, 1'b1);
    for (int i = 0; i < 13; i++) move(1, 1'b1);
    check("full length", length, 64);
    move(1, 1'b1);
    check("max grow length", length, 64);
    check("max grow tail_x", tail_x, 15);
    check("max grow tail_y", tail_y, 16);
    check_query(14, 16, 0);

    // Tick held through CHECK and COMMIT yields a single move.
    do_reset();
    @(negedge clk);
    dir = 2'd1; tick = 1'b1;
    model_step(1, 1'b0, cyc + 3);
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    check("held tick pending", sb.size(), 0);
    sb.delete();
    check("held tick head_x", head_x, 17);

    // Reset asserted while the move is in COMMIT.
    do_reset();
    @(negedge clk); dir = 2'd1; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    check("commit reset shift", shift_snake, 0);
    check("commit reset head_x", head_x, 16);
    check("commit reset tail_x", tail_x, 14);
    check("commit reset length", length, 3);
    repeat (3) @(negedge clk);
    check("commit reset head stays", head_x, 16);

    check("leftover expectations", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Owns the snake's segment list and occupancy map. Advances the snake one cell per move tick.
- Publishes head and tail coordinates plus a one-cycle shift pulse. These feed the coin placer, which samples the tail position and compares the coin against the head.
- Consumes the coin's point pulse as a grow request.
- Also answers a renderer query: is cell (query_x, query_y) occupied?

Parameters:
- H, 32, playfield width in cells; XW = ceil(log2(H)).
- V, 32, playfield height in cells; YW = ceil(log2(V)).
- MAXLEN, 64, ring-buffer depth (maximum length); LW = ceil(log2(MAXLEN+1)).
- INIT_LEN, 3, segments after reset (2..MAXLEN, must be <= H/2+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- tick  in  1  move request pulse (game-speed divider).
- dir  in  2  requested direction: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1).
- grow  in  1  point pulse from coin block.
- query_x  in  XW  renderer cell x.
- query_y  in  YW  renderer cell y.
- query_hit  out  1  occupancy of queried cell, registered.
- head_x, head_y  out  XW/YW  current head cell.
- tail_x, tail_y  out  XW/YW  current tail cell.
- shift_snake  out  1  one-cycle pulse when a move commits.
- length  out  LW  current segment count.
- dead  out  1  sticky game-over flag.

Behaviour:
- Storage: MAXLEN-entry x/y ring buffer with head_ptr and tail_ptr (mod MAXLEN). H*V-bit occupancy map.
- Reset (synchronous, overrides everything, including mid-move):
  - Occupancy map cleared.
  - Snake written horizontally at y = V/2, x = H/2-INIT_LEN+1 .. H/2.
  - head = (H/2, V/2), tail = (H/2-INIT_LEN+1, V/2).
  - dir_reg = 1 (right), length = INIT_LEN, grow_pending = 0, shift_snake = 0, dead = 0, query_hit = 0, state = RUN.
- States: RUN, CHECK, COMMIT, DEAD.
- RUN:
  - On tick, sample dir. If it is the exact opposite of dir_reg, it is ignored and dir_reg is kept; otherwise dir_reg <= dir.
  - Compute next head from the resulting direction. Go to CHECK.
- CHECK:
  - growing = (grow_pending | grow) & (length < MAXLEN).
  - Wall hit if the step would leave the field: x==H-1 going right, x==0 going left, y==0 going up, y==V-1 going down. No wrap-around.
  - Self hit if the next-head occupancy bit is set, except when next head == current tail and growing==0 (tail vacates the cell).
  - Any hit: go to DEAD. Otherwise go to COMMIT.
- COMMIT:
  - head_ptr+1; write next head; set its occupancy bit.
  - If growing: length+1, tail kept, grow_pending cleared.
  - Else: clear old tail bit, then tail_ptr+1. When next head == old tail, the bit ends set.
  - shift_snake = 1 for exactly this update. head/tail outputs show new values in the same cycle shift_snake is high. Return to RUN.
- Latency: tick sampled at edge N gives shift_snake high and updated head/tail during the cycle after edge N+2.
- tick while in CHECK/COMMIT/DEAD is dropped (not queued).
- grow:
  - Sets grow_pending in any state; a grow in RUN is therefore seen by the next CHECK.
  - A grow arriving during COMMIT applies to the following move.
  - At length == MAXLEN, the grow is discarded and grow_pending cleared at CHECK.
- DEAD: dead = 1. Outputs frozen, shift_snake = 0, ticks ignored until reset.
- Query: query_hit <= map[query_y*H + query_x] every cycle (1-cycle latency); valid in all states. Out-of-range coordinates return 0.
- All coordinate arithmetic is unsigned at XW/YW bits. Wall checks precede the increment, so no overflow is ever stored.

Test Plan:
- Reset, H=V=32, INIT_LEN=3 -> head (16,16), tail (14,16), length 3, dead 0, shift_snake 0; query (15,16) -> query_hit 1 next cycle; query (17,16) -> 0.
- tick with dir=1 -> exactly two cycles later shift_snake=1 for one cycle, head (17,16), tail (15,16), length 3; query (14,16) -> 0.
- grow pulse, then tick dir=1 -> head (17,16), tail stays (14,16), length 4. The following tick without grow -> tail (15,16), length 4.
- From reset, tick dir=3 (reverse) -> ignored, head moves to (17,16). Then dir=0 ticks until y=0, one more tick -> dead=1, no shift_snake pulse, later ticks change nothing; reset recovers.
- Grow to length 5, move right, down, left, up -> dead on the up move (self hit, body cell). Repeat at length 4 on the same loop -> head enters the vacating tail cell, no death, occupancy bit still set.
- Grow at length == MAXLEN -> length unchanged, tail advances. tick during CHECK -> dropped, only one shift_snake pulse. Reset during COMMIT -> initial state next cycle, no shift_snake.
